// File: rtl/vospi_pkg.sv
// vospi_pkg: shared constants, state encoding and header-byte helper for the
// VoSPI slave (sensor-side transmitter).
package vospi_pkg;

  localparam int          PKT_HDR_BYTES     = 4;
  localparam int          PAYLOAD_BYTES_DEF = 160;
  localparam int          LINES_DEF         = 60;
  localparam logic [15:0] DISCARD_ID_DEF    = 16'h0F00;
  // CRC checking is disabled on the link, so the field is a constant fill.
  localparam logic [15:0] CRC_FILL          = 16'h0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT
  } state_t;

  // Header bytes in wire order: ID[15:8], ID[7:0], CRC[15:8], CRC[7:0].
  function automatic logic [7:0] hdr_byte(input logic [15:0] id,
                                          input logic [1:0]  idx);
    case (idx)
      2'd0:    hdr_byte = id[15:8];
      2'd1:    hdr_byte = id[7:0];
      2'd2:    hdr_byte = CRC_FILL[15:8];
      default: hdr_byte = CRC_FILL[7:0];
    endcase
  endfunction

endpackage

// File: rtl/vospi_slave_spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchroniser for an asynchronous SPI line plus
// one-clk rise/fall pulses in the clk domain.
// Ports: clk, rst (async high), i_async (raw line), o_rise / o_fall (pulses).
// Both SPI lines idle high (CPOL=1 clock, active-low select), so the chain
// resets to 1 and no spurious edge is seen when reset is released.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/vospi_slave.sv
// vospi_slave: Lepton-side VoSPI transmitter. Serialises header + payload
// packets onto spi_miso (SPI mode 3, MSB first) for an external master.
// Ports:
//   clk, rst            system clock (>= 8x spi_clk), async active-high reset
//   spi_clk, spi_cs     master clock / active-low select (asynchronous)
//   spi_miso            serial data out
//   line_valid          sampled at packet start: video (1) or discard (0)
//   tx_data/tx_valid    upstream payload byte
//   tx_ready            pulse: payload byte consumed
//   pkt_num             number of the next video packet
//   frame_done          pulse after the last packet of a frame
//   underrun            pulse: payload byte needed but tx_valid low
//   pkt_abort           pulse: select released mid-packet
module vospi_slave
  import vospi_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
  parameter int          LINES         = LINES_DEF,
  parameter logic [15:0] DISCARD_ID    = DISCARD_ID_DEF,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs,
  output logic        spi_miso,
  input  logic        line_valid,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [11:0] pkt_num,
  output logic        frame_done,
  output logic        underrun,
  output logic        pkt_abort
);

  localparam int                PKT_BYTES = PAYLOAD_BYTES + PKT_HDR_BYTES;
  localparam int                IDX_W     = $clog2(PKT_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PKT_BYTES - 1);
  localparam logic [IDX_W-1:0]  FIRST_PAY = IDX_W'(PKT_HDR_BYTES);
  localparam logic [11:0]       LAST_LINE = 12'(LINES - 1);

  logic w_clk_rise, w_clk_fall, w_cs_rise, w_cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
    .clk(clk), .rst(rst), .i_async(spi_clk), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .i_async(spi_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [IDX_W-1:0] r_byte_idx;
  logic [2:0]       r_bit_cnt;
  logic             r_video;
  logic [15:0]      r_id;

  logic [15:0]      w_load_id;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_next_pay;
  logic [7:0]       w_next_byte;

  assign w_load_id  = line_valid ? {4'h0, pkt_num} : DISCARD_ID;
  assign w_next_idx = r_byte_idx + 1'b1;
  assign w_next_pay = (w_next_idx >= FIRST_PAY);
  // Discard payload and underrun bytes go out as zero.
  assign w_next_byte = !w_next_pay          ? hdr_byte(r_id, w_next_idx[1:0]) :
                       (r_video && tx_valid) ? tx_data : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_bit_cnt  <= '0;
      r_video    <= 1'b0;
      r_id       <= '0;
      spi_miso   <= 1'b0;
      tx_ready   <= 1'b0;
      pkt_num    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      tx_ready   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      pkt_abort  <= 1'b0;
      case (r_state)
        IDLE: begin
          spi_miso   <= 1'b0;
          r_byte_idx <= '0;
          r_bit_cnt  <= '0;
          if (w_cs_fall) r_state <= LOAD;
        end
        LOAD: begin
          if (w_cs_rise) begin
            spi_miso <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_video  <= line_valid;
            r_id     <= w_load_id;
            r_shift  <= w_load_id[15:8];
            // MSB must be on the wire before the master's first rising edge.
            spi_miso <= w_load_id[15];
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Select release has priority over any coincident clock edge.
          if (w_cs_rise) begin
            pkt_abort  <= (r_byte_idx != '0) || (r_bit_cnt != '0);
            spi_miso   <= 1'b0;
            r_byte_idx <= '0;
            r_bit_cnt  <= '0;
            r_state    <= IDLE;
          end else if (w_clk_rise) begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (r_byte_idx == LAST_IDX) begin
                r_byte_idx <= '0;
                if (r_video) begin
                  if (pkt_num == LAST_LINE) begin
                    pkt_num    <= '0;
                    frame_done <= 1'b1;
                  end else begin
                    pkt_num <= pkt_num + 12'd1;
                  end
                end
                // Still in SHIFT means select is still low: chain the next packet.
                r_state <= LOAD;
              end else begin
                r_byte_idx <= w_next_idx;
                r_shift    <= w_next_byte;
                if (w_next_pay && r_video) begin
                  tx_ready <= 1'b1;
                  underrun <= ~tx_valid;
                end
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else if (w_clk_fall) begin
            spi_miso <= r_shift[3'd7 - r_bit_cnt];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vospi_slave.sv
// Bench for vospi_slave: a mode-3 master clocks whole or partial packets at
// clk/10; expected packets are built from the packet-format rules using a
// packet counter model and an upstream byte array.
module tb_vospi_slave;
  import vospi_pkg::*;

  localparam int PB  = 16;
  localparam int LN  = 8;
  localparam int PKT = PB + PKT_HDR_BYTES;

  logic        clk = 1'b0, rst = 1'b0;
  logic        spi_clk = 1'b1, spi_cs = 1'b1, line_valid = 1'b0;
  logic        spi_miso, tx_valid, tx_ready, frame_done, underrun, pkt_abort;
  logic [7:0]  tx_data;
  logic [11:0] pkt_num;

  always #5 clk = ~clk;

  vospi_slave #(.PAYLOAD_BYTES(PB), .LINES(LN), .DISCARD_ID(16'h0F00), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_miso(spi_miso),
    .line_valid(line_valid), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pkt_num(pkt_num), .frame_done(frame_done), .underrun(underrun), .pkt_abort(pkt_abort)
  );

  // Upstream line buffer: index advances once per consumed byte; rewinds via up_off.
  logic [7:0] up_data [1024];
  logic       up_val  [1024];
  int rdy_total = 0, und_total = 0, fd_total = 0, ab_total = 0, up_off = 0;
  int up_idx;
  assign up_idx   = (rdy_total - up_off) & 1023;
  assign tx_data  = up_data[up_idx];
  assign tx_valid = up_val[up_idx];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Pulse counters (each high cycle counted, so a stretched pulse over-counts).
  int cs_hi = 0;
  always @(negedge clk) begin
    if (tx_ready)   rdy_total++;
    if (underrun)   und_total++;
    if (frame_done) fd_total++;
    if (pkt_abort)  ab_total++;
    if (rst || !spi_cs) cs_hi = 0; else cs_hi++;
    if (cs_hi == 8) chk("idle_miso", {31'd0, spi_miso}, 32'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         m_pkt = 0;
  logic [7:0] got   [PKT];
  logic [7:0] exp_b [PKT];

  task automatic xfer_byte(output logic [7:0] b);
    b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      spi_clk = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      b = {b[6:0], spi_miso};
      spi_clk = 1'b1;
      repeat (5) @(posedge clk);
      #1;
    end
  endtask

  // mode 0: payload 0,1,2..; 1: random; 2: random with byte 10 missing; 3: random drops
  task automatic fill_up(input int mode);
    int base, ix;
    base = rdy_total - up_off;
    for (int i = 0; i < PB; i++) begin
      ix = (base + i) & 1023;
      up_data[ix] = (mode == 0) ? 8'(i) : 8'($urandom);
      up_val[ix]  = (mode == 3) ? ($urandom_range(0, 7) != 0) : ((mode == 2) ? (i != 10) : 1'b1);
    end
  endtask

  task automatic run_packet(input bit lv, input int nbytes, input bit drop_cs, input bit raise_cs);
    int base, r0, u0, f0, a0, nfetch, nund, ix;
    bit wrap;
    logic [15:0] id;
    if (drop_cs) begin
      line_valid = lv;
      spi_cs = 1'b0;
      repeat (10) @(posedge clk);
      #1;
    end
    base = rdy_total - up_off;
    r0 = rdy_total; u0 = und_total; f0 = fd_total; a0 = ab_total;
    id = lv ? 16'(m_pkt) : 16'h0F00;
    exp_b[0] = id[15:8];
    exp_b[1] = id[7:0];
    exp_b[2] = 8'h00;
    exp_b[3] = 8'h00;
    for (int i = 0; i < PB; i++) begin
      ix = (base + i) & 1023;
      exp_b[PKT_HDR_BYTES + i] = (lv && up_val[ix]) ? up_data[ix] : 8'h00;
    end
    for (int i = 0; i < nbytes; i++) begin
      xfer_byte(got[i]);
      chk($sformatf("pkt%0d_byte%0d", m_pkt, i), {24'd0, got[i]}, {24'd0, exp_b[i]});
    end
    if (raise_cs) begin
      spi_cs = 1'b1;
      repeat (8) @(posedge clk);
      #1;
    end
    // Bytes are fetched one byte ahead of the wire.
    if (!lv) nfetch = 0;
    else if (nbytes == PKT) nfetch = PB;
    else begin
      nfetch = nbytes + 1 - PKT_HDR_BYTES;
      if (nfetch < 0) nfetch = 0;
    end
    nund = 0;
    for (int i = 0; i < nfetch; i++) if (!up_val[(base + i) & 1023]) nund++;
    wrap = lv && (nbytes == PKT) && (m_pkt == LN - 1);
    chk("tx_ready_count", rdy_total - r0, nfetch);
    chk("underrun_count", und_total - u0, nund);
    chk("frame_done_count", fd_total - f0, wrap ? 1 : 0);
    chk("pkt_abort_count", ab_total - a0, (raise_cs && nbytes < PKT) ? 1 : 0);
    if (nbytes == PKT) begin
      if (lv) m_pkt = (m_pkt == LN - 1) ? 0 : m_pkt + 1;
    end else begin
      up_off += nfetch;  // upstream rewinds the line
    end
    chk("pkt_num", {20'd0, pkt_num}, m_pkt);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, {31'd0, spi_miso}, 0);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 0);
    chk({tag, "_pkt_num"}, {20'd0, pkt_num}, 0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    chk({tag, "_underrun"}, {31'd0, underrun}, 0);
    chk({tag, "_pkt_abort"}, {31'd0, pkt_abort}, 0);
  endtask

  initial begin
    int f0, iter;
    bit lv;
    for (int i = 0; i < 1024; i++) begin up_data[i] = 8'h00; up_val[i] = 1'b1; end
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Video packet with incrementing payload.
    fill_up(0);
    run_packet(1'b1, PKT, 1'b1, 1'b1);
    chk("lit_first_id_lo", {24'd0, got[1]}, 32'h00);
    chk("lit_first_payload", {24'd0, got[4]}, 32'h00);
    chk("lit_last_payload", {24'd0, got[PKT-1]}, 32'h0F);
    chk("lit_pkt_num_1", {20'd0, pkt_num}, 32'd1);

    // Discard packet.
    run_packet(1'b0, PKT, 1'b1, 1'b1);
    chk("lit_discard_hi", {24'd0, got[0]}, 32'h0F);
    chk("lit_discard_lo", {24'd0, got[1]}, 32'h00);

    // Underrun on payload byte 10 only.
    fill_up(2);
    run_packet(1'b1, PKT, 1'b1, 1'b1);
    chk("lit_underrun_byte", {24'd0, got[PKT_HDR_BYTES + 10]}, 32'h00);

    iter = 0;
    while (m_pkt < 5 && iter < 20) begin
      lv = ($urandom_range(0, 3) != 0);
      fill_up(3);
      run_packet(lv, PKT, 1'b1, 1'b1);
      iter++;
    end

    // Abort mid-packet 5, then the retry must still carry ID 5.
    fill_up(1);
    run_packet(1'b1, 10, 1'b1, 1'b1);
    chk("abort_miso", {31'd0, spi_miso}, 0);
    fill_up(1);
    run_packet(1'b1, PKT, 1'b1, 1'b1);
    chk("lit_retry_id", {24'd0, got[1]}, 32'h05);

    // One frame of back-to-back packets with select held low.
    f0 = fd_total;
    line_valid = 1'b1;
    for (int k = 0; k < LN; k++) begin
      fill_up(1);
      run_packet(1'b1, PKT, k == 0, k == LN - 1);
    end
    chk("frame_done_per_frame", fd_total - f0, 1);

    // Reset in the middle of a packet.
    fill_up(1);
    run_packet(1'b1, 7, 1'b1, 1'b0);
    spi_cs = 1'b1;
    rst = 1'b1;
    #2;
    chk_reset_vals("midreset");
    m_pkt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    fill_up(1);
    run_packet(1'b1, PKT, 1'b1, 1'b1);
    chk("lit_after_reset_hi", {24'd0, got[0]}, 32'h00);
    chk("lit_after_reset_lo", {24'd0, got[1]}, 32'h00);

    for (int n = 0; n < 4; n++) begin
      lv = ($urandom_range(0, 3) != 0);
      fill_up(3);
      run_packet(lv, PKT, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
